// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: writeback result source, load kinds and the
// hard-wired zero register index.
package mips_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4
  } load_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Big-endian load lane selection and extension from an aligned memory word,
// plus the natural-alignment check for word and halfword loads.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        mis
);

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    logic signed [31:0] w;
    w = 32'(b);
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    logic signed [31:0] w;
    w = 32'(h);
    return w;
  endfunction

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane 0 is the most significant byte.
  always_comb begin
    byte_v = mem_rdata[7:0];
    case (addr)
      2'd0:    byte_v = mem_rdata[31:24];
      2'd1:    byte_v = mem_rdata[23:16];
      2'd2:    byte_v = mem_rdata[15:8];
      default: byte_v = mem_rdata[7:0];
    endcase
    half_v = addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    data = mem_rdata;
    mis  = (addr != 2'd0);
    case (load_type_e'(load_type))
      LT_LH: begin
        data = sext16(half_v);
        mis  = addr[0];
      end
      LT_LHU: begin
        data = {16'h0000, half_v};
        mis  = addr[0];
      end
      LT_LB: begin
        data = sext8(byte_v);
        mis  = 1'b0;
      end
      LT_LBU: begin
        data = {24'h000000, byte_v};
        mis  = 1'b0;
      end
      default: begin
        data = mem_rdata;
        mis  = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MIPS MEM/WB pipeline register with result selection, load alignment,
// $0 protection and a committed-write counter.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              reg_write_in,
  input  logic [4:0]        dest,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        load_type,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] pc_plus4,
  output logic [4:0]        number,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              misaligned,
  output logic [31:0]       retire_count
);

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              mis;
  logic [DATA_W-1:0] result;

  logic [4:0]        number_d,       number_q;
  logic [DATA_W-1:0] write_data_d,   write_data_q;
  logic              reg_write_d,    reg_write_q;
  logic              misaligned_d,   misaligned_q;
  logic [31:0]       retire_count_d, retire_count_q;

  load_align u_load_align (
    .mem_rdata (mem_rdata),
    .addr      (alu_result[1:0]),
    .load_type (load_type),
    .data      (ld_data),
    .mis       (ld_mis)
  );

  assign in_ready = !stall;

  always_comb begin
    mis    = in_valid && (wb_sel_e'(wb_sel) == WB_MEM) && ld_mis;
    result = alu_result;
    case (wb_sel_e'(wb_sel))
      WB_MEM:  result = ld_data;
      WB_LINK: result = pc_plus4;
      default: result = alu_result;
    endcase
  end

  // Flush forces a capture so the killed instruction never lingers behind a stall.
  always_comb begin
    number_d       = number_q;
    write_data_d   = write_data_q;
    reg_write_d    = reg_write_q;
    misaligned_d   = misaligned_q;
    retire_count_d = retire_count_q + {31'b0, reg_write_q};
    if (!stall || flush) begin
      number_d     = dest;
      write_data_d = result;
      reg_write_d  = in_valid && reg_write_in && !flush && (dest != REG_ZERO) && !mis;
      misaligned_d = in_valid && !flush && mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      number_q       <= '0;
      write_data_q   <= '0;
      reg_write_q    <= 1'b0;
      misaligned_q   <= 1'b0;
      retire_count_q <= '0;
    end else begin
      number_q       <= number_d;
      write_data_q   <= write_data_d;
      reg_write_q    <= reg_write_d;
      misaligned_q   <= misaligned_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign number       = number_q;
  assign write_data   = write_data_q;
  assign reg_write    = reg_write_q;
  assign misaligned   = misaligned_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: each cycle's expected register
// contents are queued at drive time and compared one cycle later.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic        reg_write_in;
  logic [4:0]  dest;
  logic [1:0]  wb_sel;
  logic [2:0]  load_type;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] pc_plus4;
  logic [4:0]  number;
  logic [31:0] write_data;
  logic        reg_write;
  logic        misaligned;
  logic [31:0] retire_count;

  writeback_stage #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .stall        (stall),
    .flush        (flush),
    .reg_write_in (reg_write_in),
    .dest         (dest),
    .wb_sel       (wb_sel),
    .load_type    (load_type),
    .alu_result   (alu_result),
    .mem_rdata    (mem_rdata),
    .pc_plus4     (pc_plus4),
    .number       (number),
    .write_data   (write_data),
    .reg_write    (reg_write),
    .misaligned   (misaligned),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  num;
    logic [31:0] wd;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] exp_cnt;
  int          n_tests;
  int          n_fail;

  function automatic exp_t model(input logic f);
    exp_t        e;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    logic        m;
    case (alu_result[1:0])
      2'd0:    b = mem_rdata[31:24];
      2'd1:    b = mem_rdata[23:16];
      2'd2:    b = mem_rdata[15:8];
      default: b = mem_rdata[7:0];
    endcase
    h = alu_result[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (load_type)
      3'd1:    begin ld = {{16{h[15]}}, h}; m = alu_result[0]; end
      3'd2:    begin ld = {16'h0000, h};    m = alu_result[0]; end
      3'd3:    begin ld = {{24{b[7]}}, b};  m = 1'b0; end
      3'd4:    begin ld = {24'h000000, b};  m = 1'b0; end
      default: begin ld = mem_rdata;        m = (alu_result[1:0] != 2'd0); end
    endcase
    m = m && in_valid && (wb_sel == 2'd1);
    e.num = dest;
    if (wb_sel == 2'd2)      e.wd = pc_plus4;
    else if (wb_sel == 2'd1) e.wd = ld;
    else                     e.wd = alu_result;
    e.rw  = in_valid && reg_write_in && !f && (dest != 5'd0) && !m;
    e.mis = in_valid && !f && m;
    return e;
  endfunction

  task automatic instr(input logic v, input logic rwi, input logic [4:0] d,
                       input logic [1:0] sel, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc);
    in_valid     = v;
    reg_write_in = rwi;
    dest         = d;
    wb_sel       = sel;
    load_type    = lt;
    alu_result   = alu;
    mem_rdata    = rd;
    pc_plus4     = pc;
  endtask

  // One clock: drive controls, queue the expectation, compare after the edge.
  task automatic step(input logic r, input logic s, input logic f);
    exp_t        e;
    exp_t        got;
    logic [31:0] cnt_n;
    rst   = r;
    stall = s;
    flush = f;
    #1;
    n_tests++;
    if (in_ready !== !s) begin
      n_fail++;
      $display("FAIL in_ready got=%0b exp=%0b", in_ready, !s);
    end
    if (r) begin
      e     = '0;
      cnt_n = 32'd0;
    end else begin
      cnt_n = exp_cnt + {31'b0, cur.rw};
      e     = (!s || f) ? model(f) : cur;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got     = sb.pop_front();
    cur     = got;
    exp_cnt = cnt_n;
    n_tests++;
    if (number !== got.num) begin
      n_fail++;
      $display("FAIL number got=%0d exp=%0d", number, got.num);
    end
    n_tests++;
    if (write_data !== got.wd) begin
      n_fail++;
      $display("FAIL write_data got=%08h exp=%08h", write_data, got.wd);
    end
    n_tests++;
    if (reg_write !== got.rw) begin
      n_fail++;
      $display("FAIL reg_write got=%0b exp=%0b", reg_write, got.rw);
    end
    n_tests++;
    if (misaligned !== got.mis) begin
      n_fail++;
      $display("FAIL misaligned got=%0b exp=%0b", misaligned, got.mis);
    end
    n_tests++;
    if (retire_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL retire_count got=%08h exp=%08h", retire_count, exp_cnt);
    end
  endtask

  task automatic test_reset;
    instr(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({number, write_data, reg_write, misaligned, retire_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero got num=%0d wd=%08h rw=%0b mis=%0b cnt=%08h exp all 0",
               number, write_data, reg_write, misaligned, retire_count);
    end
  endtask

  task automatic test_load_byte;
    instr(1'b1, 1'b1, 5'd8, 2'd1, 3'd3, 32'h0000_1003, 32'h1122_33F0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (write_data !== 32'hFFFF_FFF0 || number !== 5'd8 || reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL lb_lane3 got wd=%08h num=%0d rw=%0b exp wd=fffffff0 num=8 rw=1",
               write_data, number, reg_write);
    end
    instr(1'b1, 1'b1, 5'd8, 2'd1, 3'd4, 32'h0000_1003, 32'h1122_33F0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (write_data !== 32'h0000_00F0) begin
      n_fail++;
      $display("FAIL lbu_lane3 got=%08h exp=000000f0", write_data);
    end
    instr(1'b1, 1'b1, 5'd9, 2'd1, 3'd3, 32'h0000_1000, 32'h8122_33F0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    instr(1'b1, 1'b1, 5'd9, 2'd1, 3'd4, 32'h0000_1001, 32'h81A2_33F0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_half;
    logic [31:0] cnt_before;
    instr(1'b1, 1'b1, 5'd10, 2'd1, 3'd1, 32'h0000_2002, 32'hAAAA_8001, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (write_data !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL lh_low got=%08h exp=ffff8001", write_data);
    end
    instr(1'b1, 1'b1, 5'd10, 2'd1, 3'd2, 32'h0000_2000, 32'hAAAA_8001, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    cnt_before = exp_cnt + {31'b0, cur.rw};
    instr(1'b1, 1'b1, 5'd10, 2'd1, 3'd1, 32'h0000_2001, 32'hAAAA_8001, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (reg_write !== 1'b0 || misaligned !== 1'b1) begin
      n_fail++;
      $display("FAIL lh_misaligned got rw=%0b mis=%0b exp rw=0 mis=1", reg_write, misaligned);
    end
    instr(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (retire_count !== cnt_before) begin
      n_fail++;
      $display("FAIL lh_mis_nocount got=%08h exp=%08h", retire_count, cnt_before);
    end
    instr(1'b1, 1'b1, 5'd11, 2'd1, 3'd0, 32'h0000_2002, 32'h1234_5678, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    instr(1'b1, 1'b1, 5'd11, 2'd1, 3'd6, 32'h0000_2004, 32'h1234_5678, 32'h0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_link;
    instr(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'h0000_0003, 32'h0, 32'h0040_0008);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (write_data !== 32'h0040_0008 || number !== 5'd31 || reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_link got wd=%08h num=%0d rw=%0b exp wd=00400008 num=31 rw=1",
               write_data, number, reg_write);
    end
    instr(1'b1, 1'b1, 5'd0, 2'd2, 3'd0, 32'h0000_0003, 32'h0, 32'h0040_0008);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_r0 got rw=%0b exp=0", reg_write);
    end
    instr(1'b1, 1'b1, 5'd4, 2'd3, 3'd0, 32'h0000_7777, 32'h0, 32'h0040_0008);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_flush;
    logic [31:0] c0;
    instr(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    c0 = retire_count;
    instr(1'b1, 1'b1, 5'd6, 2'd0, 3'd0, 32'h0000_9999, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (write_data !== 32'h0000_1234 || number !== 5'd5 || retire_count !== c0 + 32'd3) begin
      n_fail++;
      $display("FAIL stall_hold got wd=%08h num=%0d cnt=%08h exp wd=00001234 num=5 cnt=%08h",
               write_data, number, retire_count, c0 + 32'd3);
    end
    step(1'b0, 1'b1, 1'b1);
    n_tests++;
    if (reg_write !== 1'b0 || retire_count !== c0 + 32'd4) begin
      n_fail++;
      $display("FAIL stall_flush got rw=%0b cnt=%08h exp rw=0 cnt=%08h",
               reg_write, retire_count, c0 + 32'd4);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    instr(1'b1, 1'b1, 5'd12, 2'd0, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 60; i++) begin
      instr(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      step(1'b0, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 6) == 0));
    end
  endtask

  task automatic test_wrap;
    instr(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    instr(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (retire_count !== 32'h0) begin
      n_fail++;
      $display("FAIL retire_wrap got=%08h exp=00000000", retire_count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cur     = '0;
    exp_cnt = 32'd0;
    rst     = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    instr(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    test_reset;
    test_load_byte;
    test_load_half;
    test_link;
    test_stall_flush;
    test_reset_mid;
    test_back_to_back;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
